uart_ascii_rx: RTL
==================

UART_ASCII_RX -- requirements
Module: uart_ascii_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 278, clk cycles per UART bit (32 MHz / 115200 baud).
REQ-002 Parameter STROBE_CYCLES, default 4, width in clk cycles of the dsn/clearn low pulses; legal only if 2 <= STROBE_CYCLES < CLKS_PER_BIT.
REQ-003 clk  input  1  system clock, 32 MHz; the only clock.
REQ-004 rst  input  1  reset, synchronous to clk, active-high.
REQ-005 rxd  input  1  asynchronous UART serial input, idle high, 8N1, LSB first.
REQ-006 ascii  output  8  last accepted character; held stable between strobes.
REQ-007 dsn  output  1  active-low data strobe, one pulse per accepted character.
REQ-008 clearn  output  1  active-low clear strobe, one pulse per received ESC.
REQ-009 frame_err  output  1  one-cycle high pulse per frame with a bad stop bit.
REQ-010 busy  output  1  high while a frame is being received (any state other than IDLE).

Function
REQ-011 rxd SHALL pass through a 2-flop synchroniser (flops reset to 1); all sampling uses the synchronised value.
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-013 IDLE: synchronised rxd == 0 -> START, with the bit counter cleared.
REQ-014 START: at count CLKS_PER_BIT/2 (integer division), rxd == 1 -> IDLE (glitch rejected, no outputs change); rxd == 0 -> DATA, counter cleared.
REQ-015 DATA: sample rxd every CLKS_PER_BIT cycles into a shift register, LSB first; after the 8th sample -> STOP.
REQ-016 STOP: sample after CLKS_PER_BIT cycles; rxd == 1 -> frame valid, -> IDLE; rxd == 0 -> frame_err high for exactly the next cycle, byte discarded, -> WAIT_IDLE.
REQ-017 WAIT_IDLE: remain until synchronised rxd == 1, then -> IDLE; no start bit is detected while in this state.
REQ-018 Valid byte 0x1B (ESC): clearn low for STROBE_CYCLES cycles starting the cycle after the stop sample; ascii and dsn unchanged.
REQ-019 Valid byte 0x0D or 0x0A: discarded; no strobe; ascii unchanged.
REQ-020 Any other valid byte, including 0x08 and 0x7F: ascii is loaded, and dsn goes low for STROBE_CYCLES cycles, both starting the cycle after the stop sample.
REQ-021 The strobe counter SHALL run independently of the FSM, so a start bit arriving during a strobe is received normally.
REQ-022 dsn and clearn SHALL never be low in the same cycle.
REQ-023 All counters SHALL be sized for CLKS_PER_BIT-1 and SHALL never wrap within a frame.

Reset
REQ-024 While rst is high, at every clk edge: FSM -> IDLE, counters cleared, ascii = 0x00, dsn = 1, clearn = 1, frame_err = 0, busy = 0, synchroniser flops = 1.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no strobe; the first complete frame after release SHALL be received correctly.

Verification
REQ-026 Send 0x48 ('H') at 278 clk/bit -> ascii = 0x48, dsn low for exactly 4 cycles, clearn stays 1, frame_err stays 0.
REQ-027 Send 0x1B -> clearn low for 4 cycles, dsn stays 1, ascii keeps its previous value (0x48).
REQ-028 Send 0x41 with stop bit = 0, then hold rxd low 1000 cycles, then high -> one frame_err pulse, no dsn; a following 0x42 is accepted with ascii = 0x42.
REQ-029 Drive rxd low for 50 cycles, then high -> busy pulses high, then low again; no strobes; ascii unchanged.
REQ-030 Send "HI" back-to-back with no idle gap -> two dsn pulses; ascii = 0x48, then 0x49.
REQ-031 Assert rst during bit 4 of 0x55, release, then send 0x0D followed by 0x31 -> no strobe for either the aborted frame or 0x0D; one dsn pulse with ascii = 0x31.

Source files
------------

// File: rtl/uart_ascii_rx.sv
// UART 8N1 receiver that turns incoming ASCII into a parallel character bus.
// Valid characters produce an active-low data strobe. ESC produces an
// active-low clear strobe. CR and LF are dropped. A bad stop bit produces a
// one-cycle frame-error pulse, and the receiver then waits for the line to
// return idle.
module uart_ascii_rx #(
  parameter int CLKS_PER_BIT  = 278,
  parameter int STROBE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] ascii,
  output logic       dsn,
  output logic       clearn,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int SW = $clog2(STROBE_CYCLES);
  localparam logic [CW-1:0] HALF_CNT  = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [SW-1:0] STRB_LOAD = SW'(STROBE_CYCLES - 1);
  localparam logic [7:0]    CH_ESC    = 8'h1B;
  localparam logic [7:0]    CH_CR     = 8'h0D;
  localparam logic [7:0]    CH_LF     = 8'h0A;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_sync1;
  logic            r_sync2;
  logic            w_rx;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [2:0]      r_bit;
  logic [2:0]      w_bit_nxt;
  logic [7:0]      r_shift;
  logic [7:0]      w_shift_nxt;
  logic            w_accept;
  logic            w_ferr;
  logic [7:0]      r_ascii;
  logic            r_dsn;
  logic            r_clearn;
  logic            r_frame_err;
  logic [SW-1:0]   r_strb_cnt;

  assign w_rx      = r_sync2;
  assign ascii     = r_ascii;
  assign dsn       = r_dsn;
  assign clearn    = r_clearn;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != IDLE);

  // Two-flop synchroniser for the asynchronous serial line (idles high).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
    end
  end

  // FSM state, bit-timing counter and bit index; the shift register is pure data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
    end
    r_shift <= w_shift_nxt;
  end

  // Next-state logic: mid-bit sampling, starting from the middle of the start bit.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_accept    = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (!w_rx) begin
          w_state_nxt = START;
        end
      end
      START: begin
        if (r_cnt == HALF_CNT) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = w_rx ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_cnt == LAST_CNT) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rx, r_shift[7:1]};
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
            w_state_nxt = STOP;
          end
        end
      end
      STOP: begin
        if (r_cnt == LAST_CNT) begin
          w_cnt_nxt = '0;
          if (w_rx) begin
            w_accept    = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        w_cnt_nxt = '0;
        if (w_rx) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Output strobes. The strobe timer runs independently of the FSM. Loading
  // one strobe always releases the other, so dsn and clearn are never low together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ascii     <= 8'h00;
      r_dsn       <= 1'b1;
      r_clearn    <= 1'b1;
      r_frame_err <= 1'b0;
      r_strb_cnt  <= '0;
    end else begin
      r_frame_err <= w_ferr;
      if (!r_dsn || !r_clearn) begin
        if (r_strb_cnt == '0) begin
          r_dsn    <= 1'b1;
          r_clearn <= 1'b1;
        end else begin
          r_strb_cnt <= r_strb_cnt - SW'(1);
        end
      end
      if (w_accept) begin
        if (r_shift == CH_ESC) begin
          r_clearn   <= 1'b0;
          r_dsn      <= 1'b1;
          r_strb_cnt <= STRB_LOAD;
        end else if ((r_shift != CH_CR) && (r_shift != CH_LF)) begin
          r_ascii    <= r_shift;
          r_dsn      <= 1'b0;
          r_clearn   <= 1'b1;
          r_strb_cnt <= STRB_LOAD;
        end
      end
    end
  end

endmodule
